// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer with memory-wait watchdog
// Optional macro PIPE_PERF_CNT_EN builds the saturating performance counters.
module pipe_stall_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Hazard_Detected,
    input  logic             Branch_Taken,
    input  logic             Mem_Req,
    input  logic             Sram_Ready,
    output logic             Freeze_PC,
    output logic             Freeze_IFID,
    output logic             Bubble_IDEXE,
    output logic             Flush,
    output logic             Mem_Freeze,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Wait_Cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_stall;

    // A dropped request inside a wait counts as completion, so the same term
    // decides both entering and leaving the wait.
    assign mem_stall = Mem_Req & ~Sram_Ready;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        Freeze_PC    = 1'b0;
        Freeze_IFID  = 1'b0;
        Bubble_IDEXE = 1'b0;
        Flush        = 1'b0;
        Mem_Freeze   = 1'b0;
        Mem_Timeout  = 1'b0;
        if (state_q == ST_HALT) begin
            Mem_Freeze  = 1'b1;
            Mem_Timeout = 1'b1;
        end else if (mem_stall) begin
            Mem_Freeze = 1'b1;
            if (state_q == ST_RUN) begin
                state_d    = ST_WAIT;
                wait_cnt_d = 8'd1;
            end else if (wait_cnt_q == MAX_WAIT_C) begin
                state_d = ST_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            // The release cycle of a wait is an ordinary RUN cycle.
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
            if (Branch_Taken) begin
                Flush = 1'b1;
            end else if (Hazard_Detected) begin
                Freeze_PC    = 1'b1;
                Freeze_IFID  = 1'b1;
                Bubble_IDEXE = 1'b1;
            end
        end
        if (!rst_n) begin
            Freeze_PC    = 1'b0;
            Freeze_IFID  = 1'b0;
            Bubble_IDEXE = 1'b0;
            Flush        = 1'b0;
            Mem_Freeze   = 1'b0;
            Mem_Timeout  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
            wait_cnt_perf_q <= '0;
        end else begin
            if (Bubble_IDEXE && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (Flush && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (Mem_Freeze && !(&wait_cnt_perf_q))
                wait_cnt_perf_q <= wait_cnt_perf_q + 1'b1;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
    assign Wait_Cnt  = wait_cnt_perf_q;
`else
    assign Stall_Cnt = '0;
    assign Flush_Cnt = '0;
    assign Wait_Cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - randomized and directed checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

    localparam int MAXW = 8;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Hazard_Detected = 1'b0, Branch_Taken = 1'b0, Mem_Req = 1'b0, Sram_Ready = 1'b0;
    logic Freeze_PC, Freeze_IFID, Bubble_IDEXE, Flush, Mem_Freeze, Mem_Timeout;
    logic [31:0] Stall_Cnt, Flush_Cnt, Wait_Cnt;

    int n_pass = 0;
    int n_total = 0;

    pipe_stall_ctrl #(.MAX_WAIT(MAXW), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Hazard_Detected(Hazard_Detected), .Branch_Taken(Branch_Taken),
        .Mem_Req(Mem_Req), .Sram_Ready(Sram_Ready),
        .Freeze_PC(Freeze_PC), .Freeze_IFID(Freeze_IFID), .Bubble_IDEXE(Bubble_IDEXE),
        .Flush(Flush), .Mem_Freeze(Mem_Freeze), .Mem_Timeout(Mem_Timeout),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Wait_Cnt(Wait_Cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: halted flag plus the length of the current run of stalled cycles.
    bit m_halt;
    int m_run;
    int e_stall, e_flush, e_wait;

    function automatic bit stalled_now();
        return Mem_Req && !Sram_Ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halt <= 1'b0; m_run <= 0;
            e_stall <= 0; e_flush <= 0; e_wait <= 0;
        end else if (m_halt) begin
            e_wait <= e_wait + 1;
        end else if (stalled_now()) begin
            e_wait <= e_wait + 1;
            m_run  <= m_run + 1;
            if (m_run + 1 > MAXW) m_halt <= 1'b1;
        end else begin
            m_run <= 0;
            if (Branch_Taken) e_flush <= e_flush + 1;
            else if (Hazard_Detected) e_stall <= e_stall + 1;
        end
    end

    // Per-cycle compare, sampled mid low-phase after inputs settle.
    always @(negedge clk) begin
        bit xmf, xfl, xst, xto;
        #2;
        xto = m_halt;
        xmf = m_halt || stalled_now();
        xfl = !xmf && Branch_Taken;
        xst = !xmf && !Branch_Taken && Hazard_Detected;
        if (!rst_n) begin xto = 0; xmf = 0; xfl = 0; xst = 0; end
        chk("freeze_pc",   Freeze_PC,    xst);
        chk("freeze_ifid", Freeze_IFID,  xst);
        chk("bubble",      Bubble_IDEXE, xst);
        chk("flush",       Flush,        xfl);
        chk("mem_freeze",  Mem_Freeze,   xmf);
        chk("mem_timeout", Mem_Timeout,  xto);
        chk("stall_cnt",   Stall_Cnt,    PERF ? e_stall : 0);
        chk("flush_cnt",   Flush_Cnt,    PERF ? e_flush : 0);
        chk("wait_cnt",    Wait_Cnt,     PERF ? e_wait  : 0);
    end

    task automatic drive(input logic h, input logic b, input logic m, input logic r);
        @(negedge clk);
        Hazard_Detected = h; Branch_Taken = b; Mem_Req = m; Sram_Ready = r;
        #3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        Hazard_Detected = 0; Branch_Taken = 0; Mem_Req = 0; Sram_Ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int freezes;
        logic to_hist [0:15];

        #3;
        chk("reset_freeze", Mem_Freeze, 0);
        chk("reset_cnt", Wait_Cnt, 0);
        do_reset();

        // Hazard stall
        drive(1, 0, 0, 0);
        chk("haz_pc", Freeze_PC, 1);
        chk("haz_bubble", Bubble_IDEXE, 1);
        chk("haz_flush", Flush, 0);
        drive(0, 0, 0, 0);
        chk("haz_after_pc", Freeze_PC, 0);
        chk("haz_stall_cnt", Stall_Cnt, PERF ? 1 : 0);

        // Branch beats hazard
        do_reset();
        drive(1, 1, 0, 0);
        chk("br_flush", Flush, 1);
        chk("br_pc", Freeze_PC, 0);
        chk("br_bubble", Bubble_IDEXE, 0);
        drive(0, 0, 0, 0);
        chk("br_flush_cnt", Flush_Cnt, PERF ? 1 : 0);
        chk("br_stall_cnt", Stall_Cnt, 0);

        // Four-cycle memory wait with branch held
        do_reset();
        freezes = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0);
            if (Mem_Freeze) freezes++;
            chk("mw_flush", Flush, 0);
        end
        drive(0, 1, 1, 1);
        chk("mw_freeze_count", freezes, 4);
        chk("mw_release_freeze", Mem_Freeze, 0);
        chk("mw_release_flush", Flush, 1);
        drive(0, 0, 0, 0);
        chk("mw_wait_cnt", Wait_Cnt, PERF ? 4 : 0);

        // Timeout with ready stuck low
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(0, 0, 1, 0);
            to_hist[i] = Mem_Timeout;
        end
        chk("to_cycle8", to_hist[8], 0);
        chk("to_cycle9", to_hist[9], 1);
        chk("to_cycle12", to_hist[12], 1);
        drive(0, 0, 1, 1);
        chk("to_ready_sticky", Mem_Timeout, 1);
        drive(1, 1, 0, 1);
        chk("to_halt_noflush", Flush, 0);
        do_reset();
        drive(0, 0, 0, 0);
        chk("to_cleared", Mem_Timeout, 0);

        // Async reset mid-wait
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_freeze", Mem_Freeze, 0);
        chk("ar_flush", Flush, 0);
        chk("ar_pc", Freeze_PC, 0);
        chk("ar_cnt", Wait_Cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0);
        chk("ar_haz_pc", Freeze_PC, 1);
        chk("ar_haz_freeze", Mem_Freeze, 0);

        // Randomized traffic, periodically reset to leave HALT
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 80 == 79) do_reset();
            else drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
